// File: rtl/t03_gpio_in_debouncer_if.sv
// ---------------------------------------------------------------------------
// t03_gpio_in_debouncer_if
// Edge-event handshake between the GPIO input debouncer and the consumer.
//   evt_valid  : at least one edge event is pending
//   evt_idx    : bit index of the presented event
//   evt_dir    : direction of the presented event, 1 = rise, 0 = fall
//   evt_ready  : consumer accepts the presented event
// master = debouncer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface t03_gpio_in_debouncer_if #(
  parameter int IDXW = 6
);
  logic            evt_valid;
  logic [IDXW-1:0] evt_idx;
  logic            evt_dir;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_idx,
    output evt_dir,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_idx,
    input  evt_dir,
    output evt_ready
  );
endinterface

// File: rtl/t03_gpio_in_debouncer.sv
// ---------------------------------------------------------------------------
// t03_gpio_in_debouncer
// Synchronizes the raw gpio_in pins into the clk domain, debounces each bit,
// emits one-cycle rise/fall strobes and queues per-bit edge events that are
// handed to the control FSMs one at a time over a valid/ready handshake.
// Ports:
//   clk, nrst   : system clock, asynchronous active-low reset
//   en          : block enable; low holds levels and flushes strobes/events
//   gpio_in     : raw asynchronous pin levels
//   db_out      : debounced stable levels
//   rise, fall  : one-cycle strobes when db_out changes 0->1 / 1->0
//   overflow    : sticky, an edge was dropped onto an already-pending event
//   ovf_clr     : synchronous clear of overflow
//   evt         : edge-event handshake (master side)
// ---------------------------------------------------------------------------
module t03_gpio_in_debouncer #(
  parameter int WIDTH     = 34,
  parameter int DB_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          gpio_in,
  output logic [WIDTH-1:0]          db_out,
  output logic [WIDTH-1:0]          rise,
  output logic [WIDTH-1:0]          fall,
  output logic                      overflow,
  input  logic                      ovf_clr,
  t03_gpio_in_debouncer_if.master   evt
);

  localparam int            CW       = $clog2(DB_CYCLES) + 1;
  localparam int            IW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d, flip;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [WIDTH-1:0] rp_q, rp_d, fp_q, fp_d;
  logic [WIDTH-1:0] rpClr, fpClr;
  logic             ovf_q, ovf_d, ovfSet;
  logic             evtValid, evtDir;
  logic [IW-1:0]    evtIdx;

  // Two-flop synchronizer; runs independently of en.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count consecutive samples that disagree with the
  // stable level and flip once DB_CYCLES of them have been seen. With en
  // low the counter parks at zero so debouncing restarts cleanly.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (en && (sync2_q[i] != stable_q[i])) begin
        if (cnt_q[i] == CNT_LAST) flip[i] = 1'b1;
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    stable_d = stable_q ^ flip;
    rise_d   = flip & ~stable_q;
    fall_d   = flip &  stable_q;
  end

  // Lowest pending index wins; scanning downward lets the last hit stand.
  // Rise is reported before fall on the same bit.
  always_comb begin
    evtValid = |(rp_q | fp_q);
    evtIdx   = '0;
    evtDir   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rp_q[i] || fp_q[i]) begin
        evtIdx = IW'(i);
        evtDir = rp_q[i];
      end
    end
  end

  // Pending-set update. A handshake clears only the presented entry; a new
  // edge on that same entry at the same edge re-sets it without counting as
  // a drop. Overflow set has priority over ovf_clr.
  always_comb begin
    rpClr = '0;
    fpClr = '0;
    if (evtValid && evt.evt_ready) begin
      if (evtDir) rpClr[evtIdx] = 1'b1;
      else        fpClr[evtIdx] = 1'b1;
    end
    ovfSet = en && ((|(rise_d & rp_q & ~rpClr)) || (|(fall_d & fp_q & ~fpClr)));
    rp_d   = en ? ((rp_q & ~rpClr) | rise_d) : '0;
    fp_d   = en ? ((fp_q & ~fpClr) | fall_d) : '0;
    if (ovfSet)       ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // State registers for debounce, strobes, pending sets and overflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      rp_q     <= '0;
      fp_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rp_q     <= rp_d;
      fp_q     <= fp_d;
      ovf_q    <= ovf_d;
    end
  end

  assign db_out        = stable_q;
  assign rise          = rise_q;
  assign fall          = fall_q;
  assign overflow      = ovf_q;
  assign evt.evt_valid = evtValid;
  assign evt.evt_idx   = evtIdx;
  assign evt.evt_dir   = evtDir;

endmodule

// File: tb/tb_t03_gpio_in_debouncer.sv
// ---------------------------------------------------------------------------
// tb_t03_gpio_in_debouncer
// Directed scenarios followed by randomized pin/enable/ready traffic. A
// behavioural model tracks the debounced levels from a sliding window of
// synchronized samples and keeps pending events as plain bit sets. Each
// handshake the model predicts is queued; a monitor pops the queue whenever
// the DUT completes a handshake and also checks all outputs every cycle.
// ---------------------------------------------------------------------------
module tb_t03_gpio_in_debouncer;

  localparam int W  = 34;
  localparam int DB = 4;
  localparam int IW = $clog2(W);

  logic         clk    = 1'b0;
  logic         nrst   = 1'b0;
  logic         en     = 1'b0;
  logic         ovfClr = 1'b0;
  logic [W-1:0] gpioIn = '0;
  logic [W-1:0] dbOut, riseOut, fallOut;
  logic         ovfOut;

  t03_gpio_in_debouncer_if #(.IDXW(IW)) bus ();

  t03_gpio_in_debouncer #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .gpio_in  (gpioIn),
    .db_out   (dbOut),
    .rise     (riseOut),
    .fall     (fallOut),
    .overflow (ovfOut),
    .ovf_clr  (ovfClr),
    .evt      (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] mS1, mS2, mStable, mRise, mFall, mRp, mFp;
  logic         mOvf;
  logic [W-1:0] histS2 [$];
  bit           histEn [$];
  logic         mValid, mDir;
  logic [IW-1:0] mIdx;
  logic [IW:0]  sb [$];
  int           total = 0;
  int           bad   = 0;
  int           pops  = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mS1 = '0; mS2 = '0; mStable = '0; mRise = '0; mFall = '0;
    mRp = '0; mFp = '0; mOvf = 1'b0;
    histS2.delete();
    histEn.delete();
    mValid = 1'b0; mIdx = '0; mDir = 1'b0;
  endfunction

  function automatic void modelPresent();
    mValid = 1'b0; mIdx = '0; mDir = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!mValid && (mRp[i] || mFp[i])) begin
        mValid = 1'b1;
        mIdx   = IW'(i);
        mDir   = mRp[i];
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs held before it.
  // A bit flips when the last DB synchronized samples were all taken with
  // the block enabled and all disagree with the current stable level.
  task automatic modelEdge();
    logic [W-1:0] clrR, clrF, flip, riseEv, fallEv;
    bit ok, ovfSet;
    if (!nrst) begin
      modelReset();
      return;
    end
    clrR = '0; clrF = '0; flip = '0;
    modelPresent();
    if (mValid && bus.evt_ready) begin
      if (mDir) clrR[mIdx] = 1'b1;
      else      clrF[mIdx] = 1'b1;
    end
    histS2.push_back(mS2);
    histEn.push_back(en);
    if (histS2.size() > DB) begin
      void'(histS2.pop_front());
      void'(histEn.pop_front());
    end
    for (int i = 0; i < W; i++) begin
      ok = (histS2.size() == DB);
      for (int k = 0; k < histS2.size(); k++)
        if (!histEn[k] || histS2[k][i] == mStable[i]) ok = 1'b0;
      flip[i] = ok;
    end
    riseEv = flip & ~mStable;
    fallEv = flip & mStable;
    ovfSet = (|(riseEv & mRp & ~clrR)) || (|(fallEv & mFp & ~clrF));
    if (en) begin
      mRp = (mRp & ~clrR) | riseEv;
      mFp = (mFp & ~clrF) | fallEv;
    end else begin
      mRp = '0;
      mFp = '0;
    end
    if (ovfSet)      mOvf = 1'b1;
    else if (ovfClr) mOvf = 1'b0;
    mRise   = riseEv;
    mFall   = fallEv;
    mStable = mStable ^ flip;
    mS2     = mS1;
    mS1     = gpioIn;
  endtask

  // Hold the given inputs for n clock edges, stepping the model and queuing
  // every handshake it predicts for the upcoming edge.
  task automatic applyStimulus(input logic [W-1:0] pins, input logic e, input logic r,
                               input logic c, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      modelEdge();
      gpioIn        = pins;
      en            = e;
      bus.evt_ready = r;
      ovfClr        = c;
      modelPresent();
      if (mValid && bus.evt_ready) sb.push_back({mIdx, mDir});
    end
  endtask

  // Asynchronous reset mid-run: outputs must clear without waiting a clock.
  task automatic doReset(input int holdCycles);
    @(posedge clk);
    #1;
    modelEdge();
    nrst = 1'b0;
    #1;
    checkOutput("rst_db_out", dbOut, '0);
    checkOutput("rst_rise", riseOut, '0);
    checkOutput("rst_fall", fallOut, '0);
    checkOutput("rst_evt_valid", bus.evt_valid, 1'b0);
    checkOutput("rst_overflow", ovfOut, 1'b0);
    modelReset();
    repeat (holdCycles) begin
      @(posedge clk);
      #1;
    end
    nrst = 1'b1;
  endtask

  // Monitor: per-cycle output compare plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    checkOutput("db_out", dbOut, mStable);
    checkOutput("rise", riseOut, mRise);
    checkOutput("fall", fallOut, mFall);
    checkOutput("overflow", ovfOut, mOvf);
    checkOutput("evt_valid", bus.evt_valid, mValid);
    checkOutput("evt_idx", bus.evt_idx, mIdx);
    checkOutput("evt_dir", bus.evt_dir, mDir);
    if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
      pops++;
      if (sb.size() == 0) begin
        checkOutput("evt_unexpected", {bus.evt_idx, bus.evt_dir}, '1);
      end else begin
        checkOutput("evt_pop", {bus.evt_idx, bus.evt_dir}, sb.pop_front());
      end
    end
  end

  // Directed scenarios then random traffic.
  initial begin
    logic [W-1:0] p;
    logic         r;
    modelReset();
    bus.evt_ready = 1'b0;
    p = '0;
    #2;
    checkOutput("init_db_out", dbOut, '0);
    checkOutput("init_rise", riseOut, '0);
    checkOutput("init_fall", fallOut, '0);
    checkOutput("init_evt_valid", bus.evt_valid, 1'b0);
    checkOutput("init_evt_idx", bus.evt_idx, '0);
    checkOutput("init_evt_dir", bus.evt_dir, 1'b0);
    checkOutput("init_overflow", ovfOut, 1'b0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    $display("[TB] steady input");
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 20);

    $display("[TB] clean edge on bit 5");
    p[5] = 1'b1;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 8);
    applyStimulus(p, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 3);

    $display("[TB] glitch rejection on bit 2");
    p[2] = 1'b1;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 3);
    p[2] = 1'b0;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 8);
    p[2] = 1'b1;
    applyStimulus(p, 1'b1, 1'b1, 1'b0, 4);
    p[2] = 1'b0;
    applyStimulus(p, 1'b1, 1'b1, 1'b0, 10);

    $display("[TB] simultaneous edges on bits 0, 7, 33");
    p[0] = 1'b1; p[7] = 1'b1; p[33] = 1'b1;
    applyStimulus(p, 1'b1, 1'b1, 1'b0, 12);

    $display("[TB] overflow on bit 3");
    p[3] = 1'b1;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 6);
    p[3] = 1'b0;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 6);
    p[3] = 1'b1;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 8);
    applyStimulus(p, 1'b1, 1'b1, 1'b0, 6);
    applyStimulus(p, 1'b1, 1'b0, 1'b1, 1);
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 2);

    $display("[TB] enable drop with events pending");
    p[10] = 1'b1;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 8);
    p[10] = 1'b0;
    applyStimulus(p, 1'b0, 1'b0, 1'b0, 6);
    applyStimulus(p, 1'b1, 1'b1, 1'b0, 10);

    $display("[TB] reset during a debounce count");
    p[12] = 1'b1;
    applyStimulus(p, 1'b1, 1'b0, 1'b0, 4);
    doReset(3);
    applyStimulus(p, 1'b1, 1'b1, 1'b0, 12);

    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) doReset(2);
      p = gpioIn ^ (W'({$urandom, $urandom}) & W'({$urandom, $urandom}) & W'({$urandom, $urandom}));
      r = ((c % 200) < 100) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      applyStimulus(p, ($urandom_range(0, 31) != 0), r, ($urandom_range(0, 15) == 0), 1);
    end
    applyStimulus(gpioIn, 1'b1, 1'b1, 1'b0, 90);

    checkOutput("scoreboard_empty", sb.size(), 0);
    checkOutput("handshakes_seen", (pops > 0), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t03_gpio_in_debouncer.md
# t03_gpio_in_debouncer

Input-side companion to the team_03 GPIO output drive: samples the `gpio_in` breakout pins into the `clk` domain and debounces each bit. It produces clean levels and one-cycle rise/fall strobes. Edge events are queued per bit and presented one at a time to downstream core logic over a valid/ready handshake. It sits between the top-level `gpio_in` bus and the team's control FSMs.

## Interface
- `WIDTH`, 34: number of input bits debounced (matches the `gpio_in` width).
- `DB_CYCLES`, 4: consecutive differing synchronized samples required to accept a change; legal range ≥1.
- `clk`  in  1: system clock.
- `nrst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: block enable; low freezes and flushes the block (see Operation).
- `gpio_in`  in  WIDTH: raw, asynchronous pin levels.
- `db_out`  out  WIDTH: debounced stable levels.
- `rise`  out  WIDTH: one-cycle strobe per bit when `db_out` goes 0→1.
- `fall`  out  WIDTH: one-cycle strobe per bit when `db_out` goes 1→0.
- `evt_valid`  out  1: at least one edge event is pending.
- `evt_idx`  out  $clog2(WIDTH): bit index of the presented event.
- `evt_dir`  out  1: direction of the presented event; 1 = rise, 0 = fall.
- `evt_ready`  in  1: consumer accepts the presented event.
- `overflow`  out  1: sticky flag; an edge was dropped because that bit already had an event of the same direction pending.
- `ovf_clr`  in  1: synchronous clear of `overflow`.

## Operation
- Synchronizer: two flops per bit, `s1 <= gpio_in`, `s2 <= s1`. Both reset to 0. They run regardless of `en`.
- Debounce, per bit, using counter `cnt` (width $clog2(DB_CYCLES)+1) and register `stable`:
  - If `s2 == stable`, clear `cnt`.
  - Else, if `cnt == DB_CYCLES-1`, flip `stable` and clear `cnt`.
  - Else, increment `cnt`.
  - `db_out = stable`.
- `rise`/`fall`: registered. They assert in the cycle immediately following the edge at which `stable` flipped, for exactly one cycle.
- Pending sets: two sets per bit, `rp` (rise) and `fp` (fall).
  - A stable flip sets the matching bit.
  - A flip whose matching bit is already set, and is not being cleared that same edge, leaves the bit set and sets `overflow`.
- Event presentation (combinational from the pending registers):
  - `evt_valid = |(rp|fp)`.
  - `evt_idx` = lowest index with `rp|fp` set.
  - `evt_dir = rp[evt_idx]`, so rise is presented before fall on the same bit.
  - When `evt_valid=0`, `evt_idx=0` and `evt_dir=0`.
- Handshake:
  - `evt_valid & evt_ready` at an edge clears exactly the presented bit (`rp` or `fp`).
  - A simultaneous new set of that same bit wins: the bit stays set and `overflow` is not raised.
  - `evt_ready` with `evt_valid=0` has no effect.
- `overflow`: set as above.
  - `ovf_clr` clears it.
  - If set and clear occur at the same edge, set wins.
- `en=0`:
  - `cnt` held at 0 and `stable` held.
  - `rp`, `fp`, `rise`, `fall` cleared; `evt_valid` therefore 0.
  - `overflow` held, and `ovf_clr` is still honoured.
  - When `en` rises, debounce restarts from the held `stable`.

## Timing
- Reset values: all outputs 0. That covers `db_out`, `rise`, `fall`, `evt_valid`, `evt_idx`, `evt_dir` and `overflow`; internal `s1`, `s2`, `cnt`, `rp`, `fp` are also 0.
- Latency: a pin change captured into `s1` at edge 0 flips `stable` at edge DB_CYCLES+1.
  - `db_out`, `rise`/`fall` and `evt_valid` reflect it in the cycle after that edge.
- A pulse shorter than DB_CYCLES cycles at `s2` causes no change.
- Event throughput: one event per cycle while `evt_ready` is held high.
- Asserting `nrst` mid-operation immediately clears all state, including pending events and `overflow`.

## Test plan
- Reset and steady input: reset with `gpio_in=0`, DB_CYCLES=4 -> all outputs 0; no strobes over 20 cycles.
- Clean edge: `gpio_in[5]` 0→1 captured at edge 0.
  - `db_out[5]=1` and `rise[5]=1` (one cycle) after edge 5.
  - `evt_valid=1`, `evt_idx=5`, `evt_dir=1`.
  - `evt_ready=1` for one cycle -> `evt_valid=0`.
- Glitch rejection: 3-cycle high pulse on bit 2 -> `db_out`, `rise`, `fall` and `evt_valid` never assert. Then a 4-cycle pulse -> rise on bit 2 followed by fall on bit 2.
- Simultaneous edges: bits 0, 7 and 33 rise in the same cycle, with `evt_ready` held high -> events presented on consecutive cycles as idx 0, 7, 33; then `evt_valid=0`.
- Overflow: with `evt_ready=0`, bit 3 toggles rise, fall, rise (each held ≥ DB_CYCLES).
  - `overflow=1`; pending `rp[3]` and `fp[3]` each seen once (rise presented first).
  - `ovf_clr` pulse -> `overflow=0`.
- Enable and reset mid-operation:
  - Drop `en` with events pending -> `evt_valid=0` the next cycle and `db_out` held.
  - Assert `nrst` during a debounce count -> all outputs 0 immediately.
